// File: rtl/norm_sched_pkg.sv
// Shared types for the time-shared normalization engine: FSM states,
// requester identifiers and the shift-amount width helper.
package norm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

  // Leading-zero count / shift amount must hold the value N, hence M+1 bits.
  function automatic int shamt_width(input int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/leadingzero.sv
// Leading-zero counter: returns N for an all-zero input, otherwise the
// number of zero bits above the most significant one.
module leadingzero #(
  parameter int N = 64,
  parameter int M = 6
) (
  input  logic [N-1:0] in_i,
  output logic [M:0]   cnt_o
);

  localparam int W = M + 1;

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    cnt_o = W'(N);
    for (int i = 0; i < N; i++) begin
      if (in_i[i]) begin
        cnt_o = W'(N - 1 - i);
      end else begin
        cnt_o = cnt_o;
      end
    end
  end

endmodule

// File: rtl/norm_rr_arb.sv
// Two-way round-robin arbiter; priority passes to the other requester
// whenever a served operation completes.
module norm_rr_arb
  import norm_sched_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    a_valid_i,
  input  logic    b_valid_i,
  input  logic    done_i,
  input  req_id_t done_id_i,
  output logic    gnt_a_o,
  output logic    gnt_b_o
);

  req_id_t prio_q;
  req_id_t prio_d;

  // Priority holder wins only when both request; a sole requester always wins.
  always_comb begin
    gnt_a_o = a_valid_i && (!b_valid_i || (prio_q == REQ_A));
    gnt_b_o = b_valid_i && (!a_valid_i || (prio_q == REQ_B));
    if (done_i) begin
      prio_d = (done_id_i == REQ_A) ? REQ_B : REQ_A;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= REQ_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/norm_sched.sv
// Time-shared normalizer: one LZC plus a STEP-bit-per-cycle left shifter
// serving two requesters. NORM_SCHED_BYPASS_EN skips the dummy SHIFT for lz==0.
module norm_sched
  import norm_sched_pkg::*;
#(
  parameter int N    = 64,
  parameter int M    = 6,
  parameter int STEP = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a_sig,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [N-1:0] b_sig,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sig,
  output logic [M:0]   out_shamt,
  output logic         out_zero,
  output logic         out_id,
  output logic         busy
);

  localparam int SW = shamt_width(M);
  localparam logic [SW-1:0] N_W    = SW'(N);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  state_e         state_q, state_d;
  logic [N-1:0]   work_q, work_d;
  logic [SW-1:0]  rem_q, rem_d;
  logic [SW-1:0]  shamt_q, shamt_d;
  logic           zero_q, zero_d;
  req_id_t        id_q, id_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic [SW-1:0]  lz_s;
  logic [SW-1:0]  step_s;
  logic           gnt_a_s, gnt_b_s;
  logic           done_s;

  assign done_s = (state_q == DONE) && out_ready;

  leadingzero #(
    .N (N),
    .M (M)
  ) u_lzc (
    .in_i  (work_q),
    .cnt_o (lz_s)
  );

  norm_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .done_i    (done_s),
    .done_id_i (id_q),
    .gnt_a_o   (gnt_a_s),
    .gnt_b_o   (gnt_b_s)
  );

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    id_d    = id_q;
    step_s  = '0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_a_s) begin
          a_ready = 1'b1;
          work_d  = a_sig;
          id_d    = REQ_A;
          zero_d  = 1'b0;
          shamt_d = '0;
          state_d = COUNT;
        end else if (gnt_b_s) begin
          b_ready = 1'b1;
          work_d  = b_sig;
          id_d    = REQ_B;
          zero_d  = 1'b0;
          shamt_d = '0;
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        rem_d   = lz_s;
        shamt_d = lz_s;
        if (lz_s == N_W) begin
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (lz_s == '0) begin
`ifdef NORM_SCHED_BYPASS_EN
          state_d = DONE;
`else
          state_d = SHIFT;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // step never exceeds rem, so rem cannot underflow
        step_s = (rem_q < STEP_W) ? rem_q : STEP_W;
        work_d = work_q << step_s;
        rem_d  = rem_q - step_s;
        if (rem_d == '0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      shamt_q     <= '0;
      zero_q      <= 1'b0;
      id_q        <= REQ_A;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      shamt_q     <= shamt_d;
      zero_q      <= zero_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sig   = work_q;
  assign out_shamt = shamt_q;
  assign out_zero  = zero_q;
  assign out_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_norm_sched.sv
// Randomized and directed bench for norm_sched against a behavioural model
// of normalization, latency and round-robin arbitration.
module tb_norm_sched;

`ifdef NORM_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [63:0] a_sig, b_sig;
  logic        out_valid, out_ready;
  logic [63:0] out_sig;
  logic [6:0]  out_shamt;
  logic        out_zero, out_id, busy;

  int total = 0;
  int bad   = 0;

  norm_sched #(.N(64), .M(6), .STEP(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_sig     (a_sig),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_sig     (b_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // reference model state and expectations
  bit          prio_m;
  bit          exp_id, exp_acc_a, exp_acc_b, exp_z;
  logic [63:0] exp_sig;
  int          exp_sh, exp_lat;

  // observations gathered by run_op
  logic        obs_acc_a, obs_acc_b, obs_z, obs_id, obs_post_valid, obs_post_busy;
  logic [63:0] obs_sig;
  logic [6:0]  obs_sh;
  int          obs_lat, obs_rdy_busy, obs_unstable;

  function automatic int count_lz(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) if (v[i]) return 63 - i;
    return 64;
  endfunction

  task automatic model_op(input bit av, input logic [63:0] as, input bit bv, input logic [63:0] bs);
    logic [63:0] v;
    int lz;
    exp_id    = (av && (!bv || prio_m == 1'b0)) ? 1'b0 : 1'b1;
    exp_acc_a = (exp_id == 1'b0);
    exp_acc_b = (exp_id == 1'b1);
    v         = exp_id ? bs : as;
    lz        = count_lz(v);
    exp_sh    = lz;
    exp_z     = (lz == 64);
    exp_sig   = (lz == 64) ? 64'd0 : (v << lz);
    if (lz == 64)     exp_lat = 2;
    else if (lz == 0) exp_lat = BYP ? 2 : 3;
    else              exp_lat = 2 + (lz + 15) / 16;
    prio_m = ~exp_id;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_sig = 64'd0; b_sig = 64'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    prio_m = 1'b0;
  endtask

  // Drives one operation; keeps both valids high while busy to probe for stray accepts.
  task automatic run_op(input bit av, input logic [63:0] as, input bit bv, input logic [63:0] bs, input int hold);
    @(negedge clk);
    a_valid = av; a_sig = as; b_valid = bv; b_sig = bs;
    #1;
    obs_acc_a = a_ready; obs_acc_b = b_ready;
    @(posedge clk);
    #1 a_valid = 1'b1; b_valid = 1'b1;
    obs_lat = -1; obs_rdy_busy = 0; obs_unstable = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (a_ready || b_ready) obs_rdy_busy++;
      if (out_valid) begin
        obs_lat = k;
        break;
      end
      @(posedge clk);
    end
    obs_sig = out_sig; obs_sh = out_shamt; obs_z = out_zero; obs_id = out_id;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ready || b_ready) obs_rdy_busy++;
      if ({out_valid, out_sig, out_shamt, out_zero, out_id} !== {1'b1, obs_sig, obs_sh, obs_z, obs_id})
        obs_unstable++;
    end
    out_ready = 1'b1;
    #1;
    if (a_ready || b_ready) obs_rdy_busy++;
    @(posedge clk);
    #1;
    out_ready = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    obs_post_valid = out_valid; obs_post_busy = busy;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({out_valid, busy, out_zero, out_id, a_ready, b_ready, out_shamt, out_sig} !== 78'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b busy=%b zero=%b id=%b ar=%b br=%b sh=%0d sig=%h, want all zero",
               out_valid, busy, out_zero, out_id, a_ready, b_ready, out_shamt, out_sig);
    end
  endtask

  task automatic test_lz63();
    model_op(1'b1, 64'h0000_0000_0000_0001, 1'b0, 64'd0);
    run_op(1'b1, 64'h0000_0000_0000_0001, 1'b0, 64'd0, 0);
    total++;
    if (obs_sig !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL lz63_sig: got %h want %h", obs_sig, 64'h8000_0000_0000_0000); end
    total++;
    if (obs_sh !== 7'd63) begin bad++; $display("FAIL lz63_shamt: got %0d want 63", obs_sh); end
    total++;
    if (obs_id !== 1'b0) begin bad++; $display("FAIL lz63_id: got %b want 0", obs_id); end
    total++;
    if (obs_lat !== 6) begin bad++; $display("FAIL lz63_latency: got %0d want 6", obs_lat); end
  endtask

  task automatic test_pair();
    logic [63:0] as, bs;
    do_reset();
    as = 64'h00F0_0000_0000_0000;
    bs = 64'h0001_0000_0000_0000;
    for (int r = 0; r < 3; r++) begin
      model_op(1'b1, as, 1'b1, bs);
      run_op(1'b1, as, 1'b1, bs, 0);
      total++;
      if ({obs_acc_a, obs_acc_b, obs_id} !== {exp_acc_a, exp_acc_b, exp_id}) begin
        bad++;
        $display("FAIL pair_grant%0d: got ar=%b br=%b id=%b want ar=%b br=%b id=%b",
                 r, obs_acc_a, obs_acc_b, obs_id, exp_acc_a, exp_acc_b, exp_id);
      end
      total++;
      if ({obs_sig, obs_sh} !== {exp_sig, 7'(exp_sh)}) begin
        bad++;
        $display("FAIL pair_result%0d: got sig=%h sh=%0d want sig=%h sh=%0d", r, obs_sig, obs_sh, exp_sig, exp_sh);
      end
    end
  endtask

  task automatic test_zero();
    model_op(1'b1, 64'd0, 1'b0, 64'd0);
    run_op(1'b1, 64'd0, 1'b0, 64'd0, 0);
    total++;
    if ({obs_z, obs_sh, obs_sig} !== {1'b1, 7'd64, 64'd0}) begin
      bad++;
      $display("FAIL zero_result: got z=%b sh=%0d sig=%h want z=1 sh=64 sig=0", obs_z, obs_sh, obs_sig);
    end
    total++;
    if (obs_lat !== 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", obs_lat); end
  endtask

  task automatic test_msb();
    model_op(1'b0, 64'd0, 1'b1, 64'h8000_0000_0000_0000);
    run_op(1'b0, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 0);
    total++;
    if ({obs_sh, obs_z, obs_id} !== {7'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL msb_result: got sh=%0d z=%b id=%b want sh=0 z=0 id=1", obs_sh, obs_z, obs_id);
    end
    total++;
    if (obs_lat !== (BYP ? 2 : 3)) begin bad++; $display("FAIL msb_latency: got %0d want %0d", obs_lat, BYP ? 2 : 3); end
  endtask

  task automatic test_hold();
    model_op(1'b1, 64'h0000_0F00_0000_0000, 1'b1, 64'h1);
    run_op(1'b1, 64'h0000_0F00_0000_0000, 1'b1, 64'h1, 5);
    total++;
    if (obs_unstable !== 0) begin bad++; $display("FAIL hold_stable: got %0d changes want 0", obs_unstable); end
    total++;
    if (obs_rdy_busy !== 0) begin bad++; $display("FAIL hold_no_ready: got %0d ready cycles want 0", obs_rdy_busy); end
    total++;
    if ({obs_post_valid, obs_post_busy} !== 2'b00) begin
      bad++;
      $display("FAIL hold_release: got valid=%b busy=%b want 0 0", obs_post_valid, obs_post_busy);
    end
    total++;
    if ({obs_id, obs_sig} !== {exp_id, exp_sig}) begin
      bad++;
      $display("FAIL hold_result: got id=%b sig=%h want id=%b sig=%h", obs_id, obs_sig, exp_id, exp_sig);
    end
  endtask

  task automatic test_reset_shift();
    int seen;
    // start with B priority so the post-reset grant to A is meaningful
    model_op(1'b1, 64'h1, 1'b0, 64'd0);
    run_op(1'b1, 64'h1, 1'b0, 64'd0, 0);
    @(negedge clk);
    a_valid = 1'b1; a_sig = 64'h1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    prio_m = 1'b0;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_shift_idle: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_shift_dropped: got %0d active cycles want 0", seen); end
    model_op(1'b1, 64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0100);
    run_op(1'b1, 64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0100, 0);
    total++;
    if ({obs_acc_a, obs_id} !== {1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_shift_grant: got ar=%b id=%b want ar=1 id=0", obs_acc_a, obs_id);
    end
  endtask

  task automatic test_random();
    bit av, bv;
    logic [63:0] as, bs;
    int sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 2);
      av  = (sel != 1);
      bv  = (sel != 0);
      as  = {$urandom, $urandom} >> $urandom_range(0, 64);
      bs  = {$urandom, $urandom} >> $urandom_range(0, 64);
      model_op(av, as, bv, bs);
      run_op(av, as, bv, bs, $urandom_range(0, 2));
      total++;
      if ({obs_acc_a, obs_acc_b, obs_id, obs_z, obs_sh, obs_sig} !==
          {exp_acc_a, exp_acc_b, exp_id, exp_z, 7'(exp_sh), exp_sig}) begin
        bad++;
        $display("FAIL rand_result%0d: got ar=%b br=%b id=%b z=%b sh=%0d sig=%h want ar=%b br=%b id=%b z=%b sh=%0d sig=%h",
                 n, obs_acc_a, obs_acc_b, obs_id, obs_z, obs_sh, obs_sig,
                 exp_acc_a, exp_acc_b, exp_id, exp_z, exp_sh, exp_sig);
      end
      total++;
      if (obs_lat !== exp_lat) begin bad++; $display("FAIL rand_latency%0d: got %0d want %0d", n, obs_lat, exp_lat); end
      total++;
      if ({obs_rdy_busy, obs_unstable, 30'(0), obs_post_valid, obs_post_busy} !== 96'd0) begin
        bad++;
        $display("FAIL rand_protocol%0d: got rdy_busy=%0d unstable=%0d post_valid=%b post_busy=%b want 0 0 0 0",
                 n, obs_rdy_busy, obs_unstable, obs_post_valid, obs_post_busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_sig = 64'd0; b_sig = 64'd0; prio_m = 1'b0;
    test_reset();
    test_lz63();
    test_pair();
    test_zero();
    test_msb();
    test_hold();
    test_reset_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
